joypad_poll_controller: RTL



---
 rtl/joypad_poll_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/joypad_poll_controller.sv
// joypad_poll_controller
// Scheduled poller for a SNES-style serial joypad. It periodically latches the pad,
// clocks out 16 active-low button bits, debounces each button across several polls,
// and presents held levels, one-cycle press ticks and a one-cycle valid pulse.
// Optional build macro: JOYPAD_AUTOREPEAT_EN adds per-button auto-repeat ticks.

`timescale 1ns/1ps

module joypad_poll_controller #(
    parameter int POLL_INTERVAL = 833333,
    parameter int LATCH_CYCLES  = 600,
    parameter int HALF_PERIOD   = 300,
    parameter int STABLE_POLLS  = 3,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_RATE   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] outButtons,
    output logic [15:0] outButtons_tick,
    output logic        outValid
);

    localparam int TIMER_W = $clog2(POLL_INTERVAL);
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int PHASE_W = $clog2(PHASE_MAX + 1);
    localparam int STAB_W = $clog2(STABLE_POLLS + 1);

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 1);
    localparam logic [PHASE_W-1:0] LATCH_LAST   = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST    = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST    = STAB_W'(STABLE_POLLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT_HIGH,
        SAMPLE,
        CLK_LOW,
        DONE
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [TIMER_W-1:0]         poll_timer;
    logic [PHASE_W-1:0]         phase_cnt;
    logic [3:0]                 bit_index;
    logic [15:0]                shift_reg;
    logic [15:0][STAB_W-1:0]    stab;
    logic [15:0][STAB_W-1:0]    next_stab;
    logic [15:0]                next_buttons;
    logic [15:0]                press_mask;
    logic [15:0]                repeat_mask;
    logic                       poll_start;

    assign poll_start = (state == IDLE) && (poll_timer == '0);

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing of latch, sixteen high/sample phases and fifteen low phases.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (poll_start) next_state = LATCH;
            LATCH:     if (phase_cnt == LATCH_LAST) next_state = WAIT_HIGH;
            WAIT_HIGH: if (phase_cnt == HALF_LAST) next_state = SAMPLE;
            SAMPLE:    next_state = (bit_index == 4'd15) ? DONE : CLK_LOW;
            CLK_LOW:   if (phase_cnt == HALF_LAST) next_state = WAIT_HIGH;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Pad pins decoded from state: latch only in LATCH, clock low only in CLK_LOW.
    always_comb begin
        pad_latch = (state == LATCH);
        pad_clk   = (state != CLK_LOW);
    end

    // Poll timer runs continuously and is reloaded when a poll is launched.
    always_ff @(posedge clock) begin
        if (reset) begin
            poll_timer <= '0;
        end else if (poll_start) begin
            poll_timer <= TIMER_RELOAD;
        end else if (poll_timer != '0) begin
            poll_timer <= poll_timer - TIMER_W'(1);
        end
    end

    // Phase counter times the latch and half-period states, restarting on every state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (next_state != state) begin
            phase_cnt <= '0;
        end else if (state == LATCH || state == WAIT_HIGH || state == CLK_LOW) begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
        end
    end

    // Serial capture: each SAMPLE stores the inverted pad bit at the current index.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_index <= '0;
            shift_reg <= '0;
        end else if (poll_start) begin
            bit_index <= '0;
        end else if (state == SAMPLE) begin
            shift_reg[bit_index] <= ~pad_data;
            if (bit_index != 4'd15) begin
                bit_index <= bit_index + 4'd1;
            end
        end
    end

    // Debounce: a button flips only after STABLE_POLLS consecutive polls disagree with it.
    always_comb begin
        next_buttons = outButtons;
        next_stab    = '0;
        for (int i = 0; i < 16; i++) begin
            if (shift_reg[i] != outButtons[i]) begin
                if (stab[i] == STAB_LAST) begin
                    next_buttons[i] = ~outButtons[i];
                end else begin
                    next_stab[i] = stab[i] + STAB_W'(1);
                end
            end
        end
        press_mask = next_buttons & ~outButtons;
    end

`ifdef JOYPAD_AUTOREPEAT_EN
    localparam logic [7:0] REP_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] REP_RATE  = 8'(REPEAT_RATE);

    logic [15:0][7:0] held_cnt;
    logic [15:0][7:0] next_held;

    // Held-poll counting and repeat tick selection for buttons pressed on consecutive polls.
    always_comb begin
        next_held   = held_cnt;
        repeat_mask = '0;
        for (int i = 0; i < 16; i++) begin
            if (!next_buttons[i]) begin
                next_held[i] = '0;
            end else if (outButtons[i] && held_cnt[i] != 8'hFF) begin
                next_held[i] = held_cnt[i] + 8'd1;
                if (next_held[i] >= REP_DELAY &&
                    ((next_held[i] - REP_DELAY) % REP_RATE) == 8'd0) begin
                    repeat_mask[i] = 1'b1;
                end
            end
        end
    end

    // Held counters advance once per completed poll.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_cnt <= '0;
        end else if (state == DONE) begin
            held_cnt <= next_held;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign repeat_mask = '0;
`endif

    // Registered outputs commit on leaving DONE; tick and valid last exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            outButtons      <= '0;
            outButtons_tick <= '0;
            outValid        <= 1'b0;
            stab            <= '0;
        end else begin
            outValid        <= (state == DONE);
            outButtons_tick <= '0;
            if (state == DONE) begin
                outButtons      <= next_buttons;
                outButtons_tick <= press_mask | repeat_mask;
                stab            <= next_stab;
            end
        end
    end

endmodule
